// File: rtl/sargantana_icache_refill_unit.sv
// I-cache refill engine: takes one miss, issues one ifill request, gathers N_BEATS
// response beats into a line and presents it for a single cycle for the array write.
module sargantana_icache_refill_unit #(
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 128,
  parameter int PADDR_SIZE = 26,
  parameter int N_WAY      = 4,
  localparam int N_BEATS    = LINE_WIDTH / BEAT_WIDTH,
  localparam int WAY_W      = (N_WAY > 1) ? $clog2(N_WAY) : 1,
  localparam int BEAT_IDX_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [PADDR_SIZE-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]      miss_way_i,
  input  logic                  kill_i,
  output logic                  ifill_req_valid_o,
  output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
  output logic [WAY_W-1:0]      ifill_req_way_o,
  input  logic                  ifill_ack_i,
  input  logic                  ifill_resp_valid_i,
  input  logic [BEAT_IDX_W-1:0] ifill_resp_beat_i,
  input  logic [BEAT_WIDTH-1:0] ifill_resp_data_i,
  output logic                  fill_valid_o,
  output logic [LINE_WIDTH-1:0] fill_line_o,
  output logic [WAY_W-1:0]      fill_way_o,
  output logic [PADDR_SIZE-1:0] fill_paddr_o,
  output logic                  busy_o,
  output logic                  err_o
);

  // The counter is one bit wider than a beat index so it can reach N_BEATS without wrapping.
  localparam int CNT_W = BEAT_IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      beat_ext;

  assign beat_ext = {1'b0, ifill_resp_beat_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      paddr_q <= '0;
      way_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      paddr_q <= paddr_d;
      way_q   <= way_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    paddr_d = paddr_q;
    way_d   = way_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = ifill_resp_valid_i;
        if (miss_valid_i && !kill_i) begin
          paddr_d = miss_paddr_i;
          way_d   = miss_way_i;
          cnt_d   = '0;
          line_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        err_d = ifill_resp_valid_i;
        if (kill_i) begin
          // Once acked, the L2 will send beats regardless, so they must be drained.
          state_d = ifill_ack_i ? S_DRAIN : S_IDLE;
        end else if (ifill_ack_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifill_resp_valid_i) begin
          err_d = (beat_ext != cnt_q);
          cnt_d = cnt_q + 1'b1;
        end
        if (kill_i) begin
          if (ifill_resp_valid_i && cnt_q == LAST_CNT) state_d = S_IDLE;
          else                                         state_d = S_DRAIN;
        end else if (ifill_resp_valid_i) begin
          for (int k = 0; k < N_BEATS; k++) begin
            if (ifill_resp_beat_i == BEAT_IDX_W'(k))
              line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = ifill_resp_data_i;
          end
          if (cnt_q == LAST_CNT) state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = ifill_resp_valid_i;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (ifill_resp_valid_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign miss_ready_o      = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign ifill_req_valid_o = (state_q == S_REQ);
  assign ifill_req_paddr_o = paddr_q;
  assign ifill_req_way_o   = way_q;
  assign fill_valid_o      = (state_q == S_DONE);
  assign fill_line_o       = line_q;
  assign fill_way_o        = way_q;
  assign fill_paddr_o      = paddr_q;
  assign err_o             = err_q;

endmodule
